load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory request into a handshaked,
// byte-lane-masked data bus transaction and returns aligned, extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_rw,
  input  logic [1:0]  wsel,
  input  logic [2:0]  rsel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_align,
  output logic        err_bus,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    l_rsel, l_rsel_nxt;
  logic [1:0]    l_off, l_off_nxt;

  logic          done_nxt, err_align_nxt, err_bus_nxt;
  logic [31:0]   rdata_nxt;
  logic          m_req_nxt, m_we_nxt;
  logic [31:0]   m_addr_nxt, m_wdata_nxt;
  logic [3:0]    m_be_nxt;

  logic          is_word, is_half, is_byte, bad_req;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [31:0]   shifted, load_data;
  logic          tmo;

  // Decode access width, legality, byte lanes and replicated store data
  always_comb begin
    is_word = 1'b0;
    is_half = 1'b0;
    is_byte = 1'b0;
    if (mem_rw) begin
      case (wsel)
        2'd0:    is_word = 1'b1;
        2'd1:    is_half = 1'b1;
        2'd2:    is_byte = 1'b1;
        default: ;
      endcase
    end else begin
      case (rsel)
        3'd0:       is_word = 1'b1;
        3'd1, 3'd3: is_half = 1'b1;
        3'd2, 3'd4: is_byte = 1'b1;
        default:    ;
      endcase
    end
    bad_req = !(is_word || is_half || is_byte)
            || (is_word && (addr[1:0] != 2'b00))
            || (is_half && addr[0]);
    req_be    = 4'b0000;
    req_wdata = wdata;
    if (is_word) begin
      req_be    = 4'b1111;
      req_wdata = wdata;
    end else if (is_half) begin
      req_be    = 4'b0011 << addr[1:0];
      req_wdata = {2{wdata[15:0]}};
    end else if (is_byte) begin
      req_be    = 4'b0001 << addr[1:0];
      req_wdata = {4{wdata[7:0]}};
    end
  end

  // Align the returned word to the addressed lane and extend per load type
  always_comb begin
    shifted = m_rdata >> {l_off, 3'b000};
    case (l_rsel)
      3'd0:    load_data = shifted;
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd3:    load_data = {16'h0000, shifted[15:0]};
      3'd4:    load_data = {24'h000000, shifted[7:0]};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Last allowed cycle in REQ+WAIT; a completion in this cycle still wins
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  // Pipeline hold; follows req_valid combinationally while idle
  assign stall = rst_n && (((state == S_IDLE) && req_valid)
                           || (state == S_REQ) || (state == S_WAIT));

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    l_rsel_nxt    = l_rsel;
    l_off_nxt     = l_off;
    done_nxt      = 1'b0;
    m_req_nxt     = 1'b0;
    err_align_nxt = err_align;
    err_bus_nxt   = err_bus;
    rdata_nxt     = rdata;
    m_we_nxt      = m_we;
    m_addr_nxt    = m_addr;
    m_be_nxt      = m_be;
    m_wdata_nxt   = m_wdata;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          l_rsel_nxt  = rsel;
          l_off_nxt   = addr[1:0];
          m_we_nxt    = mem_rw;
          m_addr_nxt  = {addr[31:2], 2'b00};
          m_be_nxt    = req_be;
          m_wdata_nxt = req_wdata;
          if (bad_req) begin
            state_nxt     = S_DONE;
            done_nxt      = 1'b1;
            err_align_nxt = 1'b1;
            err_bus_nxt   = 1'b0;
          end else begin
            state_nxt = S_REQ;
            m_req_nxt = 1'b1;
            cnt_nxt   = '0;
          end
        end
      end
      S_REQ: begin
        cnt_nxt = cnt + CW'(1);
        if (m_gnt) begin
          if (m_we) begin
            state_nxt     = S_DONE;
            done_nxt      = 1'b1;
            err_align_nxt = 1'b0;
            err_bus_nxt   = 1'b0;
          end else if (m_rvalid) begin
            state_nxt     = S_DONE;
            done_nxt      = 1'b1;
            err_align_nxt = 1'b0;
            err_bus_nxt   = 1'b0;
            rdata_nxt     = load_data;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (tmo) begin
          state_nxt     = S_DONE;
          done_nxt      = 1'b1;
          err_align_nxt = 1'b0;
          err_bus_nxt   = 1'b1;
          rdata_nxt     = 32'h0000_0000;
        end else begin
          m_req_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt + CW'(1);
        if (m_rvalid) begin
          state_nxt     = S_DONE;
          done_nxt      = 1'b1;
          err_align_nxt = 1'b0;
          err_bus_nxt   = 1'b0;
          rdata_nxt     = load_data;
        end else if (tmo) begin
          state_nxt     = S_DONE;
          done_nxt      = 1'b1;
          err_align_nxt = 1'b0;
          err_bus_nxt   = 1'b1;
          rdata_nxt     = 32'h0000_0000;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, latched fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      l_rsel    <= 3'd0;
      l_off     <= 2'd0;
      done      <= 1'b0;
      rdata     <= 32'h0000_0000;
      err_align <= 1'b0;
      err_bus   <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= 32'h0000_0000;
      m_be      <= 4'b0000;
      m_wdata   <= 32'h0000_0000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      l_rsel    <= l_rsel_nxt;
      l_off     <= l_off_nxt;
      done      <= done_nxt;
      rdata     <= rdata_nxt;
      err_align <= err_align_nxt;
      err_bus   <= err_bus_nxt;
      m_req     <= m_req_nxt;
      m_we      <= m_we_nxt;
      m_addr    <= m_addr_nxt;
      m_be      <= m_be_nxt;
      m_wdata   <= m_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a short bus timeout.
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        mem_rw;
  logic [1:0]  wsel;
  logic [2:0]  rsel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err_align;
  logic        err_bus;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_rw(mem_rw),
    .wsel(wsel), .rsel(rsel), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err_align(err_align),
    .err_bus(err_bus), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        ea;
    logic        eb;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rdata = 32'h0;
  int          iters;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Pop the oldest expectation on every completion pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_rd) check_eq("sb_rdata", rdata, e.rdata);
        check_eq("sb_err_align", 32'(err_align), 32'(e.ea));
        check_eq("sb_err_bus", 32'(err_bus), 32'(e.eb));
      end
    end
  end

  // One request: gd = REQ cycles before m_gnt, rd = cycles from m_gnt to m_rvalid
  task automatic run_op(input string tag, input logic rw, input logic [1:0] ws,
                        input logic [2:0] rs, input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] rword,
                        input logic ea, input logic eb, input logic [31:0] erd,
                        input logic [3:0] ebe, input logic [31:0] ewd, output int n);
    exp_t e;
    n = 0;
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    req_valid = 1'b1; mem_rw = rw; wsel = ws; rsel = rs; addr = a; wdata = wd;
    #1 check_eq({tag, "_stall_idle"}, 32'(stall), 32'd1);
    e.ea = ea;
    e.eb = eb;
    e.chk_rd = !ea;
    e.rdata = eb ? 32'h0 : (rw ? last_rdata : erd);
    sb.push_back(e);
    if (!ea) last_rdata = e.rdata;
    @(negedge clk);
    req_valid = 1'b0; mem_rw = ~rw; addr = $urandom; wdata = $urandom;
    if (ea) begin
      check_eq({tag, "_no_req"}, 32'(m_req), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_stall_done"}, 32'(stall), 32'd0);
    end else begin
      check_eq({tag, "_m_req"}, 32'(m_req), 32'd1);
      check_eq({tag, "_m_we"}, 32'(m_we), 32'(rw));
      check_eq({tag, "_m_addr"}, m_addr, {a[31:2], 2'b00});
      check_eq({tag, "_m_be"}, 32'(m_be), 32'(ebe));
      if (rw) check_eq({tag, "_m_wdata"}, m_wdata, ewd);
      for (int c = 0; c < 16 && !done; c++) begin
        check_eq({tag, "_stall_busy"}, 32'(stall), 32'd1);
        if (c == gd) check_eq({tag, "_m_addr_hold"}, m_addr, {a[31:2], 2'b00});
        if (!rw && rd > 0 && c == gd + 1) check_eq({tag, "_wait_no_req"}, 32'(m_req), 32'd0);
        m_gnt    = (c == gd);
        m_rvalid = !rw && (c == gd + rd);
        m_rdata  = (c == gd + rd) ? rword : $urandom;
        n++;
        @(negedge clk);
      end
      m_gnt = 1'b0; m_rvalid = 1'b0;
      check_eq({tag, "_done"}, 32'(done), 32'd1);
      check_eq({tag, "_m_req_off"}, 32'(m_req), 32'd0);
      check_eq({tag, "_stall_done"}, 32'(stall), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_rw = 1'b0; wsel = 2'd0; rsel = 3'd0;
    addr = 32'h0; wdata = 32'h0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_errs", {30'd0, err_align, err_bus}, 32'd0);
    check_eq("rst_m_req", {31'd0, m_req}, 32'd0);
    check_eq("rst_m_we", {31'd0, m_we}, 32'd0);
    check_eq("rst_m_addr", m_addr, 32'h0);
    check_eq("rst_m_be", {28'd0, m_be}, 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'h0);
    rst_n = 1'b1;

    // Stores
    run_op("sw", 1'b1, 2'd0, 3'd0, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0,
           1'b0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF, iters);
    check_eq("sw_busy_cycles", 32'(iters + 1), 32'd3);
    run_op("sb", 1'b1, 2'd2, 3'd0, 32'h103, 32'h000000A5, 0, 0, 32'h0,
           1'b0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5, iters);
    run_op("sh", 1'b1, 2'd1, 3'd0, 32'h102, 32'h1234ABCD, 0, 0, 32'h0,
           1'b0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD, iters);

    // Loads with alignment and extension
    run_op("lb", 1'b0, 2'd0, 3'd2, 32'h102, 32'h0, 0, 1, 32'h1280FF34,
           1'b0, 1'b0, 32'hFFFFFF80, 4'b0100, 32'h0, iters);
    check_eq("lb_cycles", 32'(iters), 32'd2);
    run_op("lbu", 1'b0, 2'd0, 3'd4, 32'h102, 32'h0, 1, 1, 32'h1280FF34,
           1'b0, 1'b0, 32'h00000080, 4'b0100, 32'h0, iters);
    run_op("lhu", 1'b0, 2'd0, 3'd3, 32'h102, 32'h0, 0, 2, 32'h1280FF34,
           1'b0, 1'b0, 32'h00001280, 4'b1100, 32'h0, iters);
    run_op("lh", 1'b0, 2'd0, 3'd1, 32'h100, 32'h0, 0, 1, 32'h00008001,
           1'b0, 1'b0, 32'hFFFF8001, 4'b0011, 32'h0, iters);
    run_op("lw_fast", 1'b0, 2'd0, 3'd0, 32'h104, 32'h0, 0, 0, 32'hCAFEF00D,
           1'b0, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0, iters);
    check_eq("lw_fast_cycles", 32'(iters), 32'd1);

    // Grant on the last allowed cycle completes; rdata kept across a store
    run_op("sw_limit", 1'b1, 2'd0, 3'd0, 32'h208, 32'h01020304, 3, 0, 32'h0,
           1'b0, 1'b0, 32'h0, 4'b1111, 32'h01020304, iters);
    check_eq("sw_limit_cycles", 32'(iters), 32'd4);

    // Illegal / misaligned requests
    run_op("lw_mis", 1'b0, 2'd0, 3'd0, 32'h101, 32'h0, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, iters);
    run_op("sh_mis", 1'b1, 2'd1, 3'd0, 32'h101, 32'h5555, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, iters);
    run_op("ws3", 1'b1, 2'd3, 3'd0, 32'h100, 32'h0, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, iters);
    run_op("rs5", 1'b0, 2'd0, 3'd5, 32'h100, 32'h0, 0, 0, 32'h0,
           1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, iters);

    // Timeouts in REQ and in WAIT
    run_op("sw_tmo", 1'b1, 2'd0, 3'd0, 32'h300, 32'h0, 99, 0, 32'h0,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, iters);
    check_eq("sw_tmo_cycles", 32'(iters), 32'd4);
    run_op("lw_ok", 1'b0, 2'd0, 3'd0, 32'h304, 32'h0, 0, 0, 32'h89ABCDEF,
           1'b0, 1'b0, 32'h89ABCDEF, 4'b1111, 32'h0, iters);
    run_op("lw_tmo", 1'b0, 2'd0, 3'd0, 32'h308, 32'h0, 1, 10, 32'h11111111,
           1'b0, 1'b1, 32'h0, 4'b1111, 32'h0, iters);
    check_eq("lw_tmo_cycles", 32'(iters), 32'd4);

    // Reset while in REQ
    @(negedge clk);
    req_valid = 1'b1; mem_rw = 1'b0; rsel = 3'd0; addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rstreq_m_req_before", 32'(m_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstreq_m_req", 32'(m_req), 32'd0);
    check_eq("rstreq_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in WAIT; a late m_rvalid must be ignored
    @(negedge clk);
    req_valid = 1'b1; mem_rw = 1'b0; rsel = 3'd0; addr = 32'h404;
    @(negedge clk);
    req_valid = 1'b0; m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    check_eq("rstwait_stall_before", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstwait_stall", 32'(stall), 32'd0);
    check_eq("rstwait_m_req", 32'(m_req), 32'd0);
    check_eq("rstwait_done", 32'(done), 32'd0);
    last_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'hBADBAD00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_rvalid_done", 32'(done), 32'd0);
      check_eq("late_rvalid_stall", 32'(stall), 32'd0);
    end
    m_rvalid = 1'b0;

    // Still functional after reset
    run_op("lbu_post", 1'b0, 2'd0, 3'd4, 32'h501, 32'h0, 0, 1, 32'h0000F700,
           1'b0, 1'b0, 32'h000000F7, 4'b0010, 32'h0, iters);

    @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
